ats21_cmd_issuer: RTL and testbench

Upstream command issuer for the ATS21 alarm/timer system. Accepts complete 32-bit instructions from two independent clients (A and B) over valid/ready handshakes and buffers each client in its own FIFO. Pairs the FIFO heads into one ATS21 transaction: `req` pulse, high half-words, low half-words. Waits for the ATS21 response and returns `stat`/`data` to the clients.

---
 rtl/ats21_pkg.sv | 35 +++
 rtl/ats21_instr_fifo.sv | 55 +++++
 rtl/ats21_cmd_issuer.sv | 128 ++++++++++++
 tb/tb_ats21_cmd_issuer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 command issuer.
package ats21_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned STAT_W  = 2;
   localparam int unsigned DATA_W  = 24;

   typedef enum logic [2:0] {
      NOP       = 3'b000,
      SET_CLK   = 3'b001,
      TOGGLE_BC = 3'b010,
      SET_MODE  = 3'b011,
      SET_ALARM = 3'b101,
      SET_CNTDN = 3'b110,
      TOGGLE_AT = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WORD_HI,
      WORD_LO,
      WAIT_RSP
   } issuer_state_e;

   typedef struct packed {
      logic [STAT_W-1:0] stat;
      logic [DATA_W-1:0] data;
   } ats_rsp_t;

   localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [STAT_W-1:0]  STAT_TIMEOUT = 2'b11;

endpackage

// File: rtl/ats21_instr_fifo.sv
// Per-client instruction FIFO; power-of-two depth so the pointers wrap naturally.
module ats21_instr_fifo
   import ats21_pkg::*;
#(
   parameter int unsigned WIDTH = INSTR_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// Pairs the A/B FIFO heads into one ATS21 transaction and returns the response.
module ats21_cmd_issuer
   import ats21_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned RESP_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                a_valid,
   input  logic [INSTR_W-1:0]  a_instr,
   output logic                a_ready,
   input  logic                b_valid,
   input  logic [INSTR_W-1:0]  b_instr,
   output logic                b_ready,
   output logic                req,
   output logic [WORD_W-1:0]   ctrlA,
   output logic [WORD_W-1:0]   ctrlB,
   input  logic                ats_ready,
   input  logic [STAT_W-1:0]   ats_stat,
   input  logic [DATA_W-1:0]   ats_data,
   output logic                rsp_valid,
   output logic [STAT_W-1:0]   rsp_stat,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_timeout,
   output logic                busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned TMO_W = $clog2(RESP_TIMEOUT);

   issuer_state_e      state;
   logic [INSTR_W-1:0] ir_a;
   logic [INSTR_W-1:0] ir_b;
   logic [INSTR_W-1:0] a_head;
   logic [INSTR_W-1:0] b_head;
   logic               a_full, a_empty, b_full, b_empty;
   logic [CNT_W-1:0]   a_count, b_count;
   logic               launch;
   logic [TMO_W-1:0]   wait_cnt;
   ats_rsp_t           rsp;

   assign launch  = (state == IDLE) && ((a_count != '0) || (b_count != '0));
   assign a_ready = !a_full && reset;
   assign b_ready = !b_full && reset;

   ats21_instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .reset(reset), .push(a_valid && a_ready), .wdata(a_instr),
      .pop(launch), .rdata(a_head), .full(a_full), .empty(a_empty), .count(a_count)
   );

   ats21_instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .reset(reset), .push(b_valid && b_ready), .wdata(b_instr),
      .pop(launch), .rdata(b_head), .full(b_full), .empty(b_empty), .count(b_count)
   );

   // Outputs are registered alongside the state so they decode the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ir_a        <= NOP_INSTR;
         ir_b        <= NOP_INSTR;
         wait_cnt    <= '0;
         req         <= 1'b0;
         ctrlA       <= '0;
         ctrlB       <= '0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp         <= '0;
      end else begin
         req       <= 1'b0;
         ctrlA     <= '0;
         ctrlB     <= '0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  ir_a  <= a_empty ? NOP_INSTR : a_head;
                  ir_b  <= b_empty ? NOP_INSTR : b_head;
                  req   <= 1'b1;
                  busy  <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               ctrlA <= ir_a[31:16];
               ctrlB <= ir_b[31:16];
               state <= WORD_HI;
            end
            WORD_HI: begin
               ctrlA <= ir_a[15:0];
               ctrlB <= ir_b[15:0];
               state <= WORD_LO;
            end
            WORD_LO: begin
               wait_cnt <= '0;
               state    <= WAIT_RSP;
            end
            WAIT_RSP: begin
               if (ats_ready) begin
                  rsp         <= '{stat: ats_stat, data: ats_data};
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (wait_cnt == TMO_W'(RESP_TIMEOUT - 1)) begin
                  rsp         <= '{stat: STAT_TIMEOUT, data: '0};
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TMO_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign rsp_stat = rsp.stat;
   assign rsp_data = rsp.data;

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Randomized and directed bench for ats21_cmd_issuer against a transaction-timeline model.
module tb_ats21_cmd_issuer;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [31:0] a_instr = '0, b_instr = '0;
   logic        a_ready, b_ready;
   logic        req;
   logic [15:0] ctrlA, ctrlB;
   logic        ats_ready = 1'b0;
   logic [1:0]  ats_stat = '0;
   logic [23:0] ats_data = '0;
   logic        rsp_valid, rsp_timeout, busy;
   logic [1:0]  rsp_stat;
   logic [23:0] rsp_data;

   always #5 clk = ~clk;

   ats21_cmd_issuer #(.DEPTH(DEPTH), .RESP_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
      .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
      .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
      .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
      .rsp_valid(rsp_valid), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Model: per-client queues plus the age of the transaction in flight.
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   bit          m_act = 1'b0;
   int          m_age = 0;
   logic [31:0] m_ia = '0, m_ib = '0;
   bit          m_rv = 1'b0, m_rto = 1'b0;
   logic [1:0]  m_rs = '0;
   logic [23:0] m_rd = '0;
   int          n_txn = 0;

   always @(posedge clk) begin : model
      bit acc_a, acc_b;
      acc_a = a_valid && (qa.size() < DEPTH);
      acc_b = b_valid && (qb.size() < DEPTH);
      if (!reset) begin
         qa.delete();
         qb.delete();
         m_act = 1'b0;
         m_rv  = 1'b0;
      end else begin
         m_rv = 1'b0;
         if (!m_act) begin
            if (qa.size() > 0 || qb.size() > 0) begin
               m_ia = 32'h0;
               m_ib = 32'h0;
               if (qa.size() > 0) m_ia = qa.pop_front();
               if (qb.size() > 0) m_ib = qb.pop_front();
               m_act = 1'b1;
               m_age = 0;
               n_txn++;
            end
         end else if (m_age >= 3 && ats_ready) begin
            m_act = 1'b0; m_rv = 1'b1; m_rto = 1'b0; m_rs = ats_stat; m_rd = ats_data;
         end else if (m_age - 3 == TMO - 1) begin
            m_act = 1'b0; m_rv = 1'b1; m_rto = 1'b1; m_rs = 2'b11; m_rd = 24'h0;
         end else begin
            m_age++;
         end
         if (acc_a) qa.push_back(a_instr);
         if (acc_b) qb.push_back(b_instr);
      end
   end

   function automatic logic [15:0] exp_ctrl(input logic [31:0] ir);
      if (!m_act)      return 16'h0;
      if (m_age == 1)  return ir[31:16];
      if (m_age == 2)  return ir[15:0];
      return 16'h0;
   endfunction

   always @(negedge clk) begin : compare
      chk("req", 32'(req), 32'(m_act && m_age == 0));
      chk("ctrlA", 32'(ctrlA), 32'(exp_ctrl(m_ia)));
      chk("ctrlB", 32'(ctrlB), 32'(exp_ctrl(m_ib)));
      chk("busy", 32'(busy), 32'(m_act));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("a_ready", 32'(a_ready), 32'(reset && qa.size() < DEPTH));
      chk("b_ready", 32'(b_ready), 32'(reset && qb.size() < DEPTH));
      if (m_rv) begin
         chk("rsp_stat", 32'(rsp_stat), 32'(m_rs));
         chk("rsp_data", 32'(rsp_data), 32'(m_rd));
         chk("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
      end
   end

   task automatic wait_not_busy(input string nm);
      int w;
      w = 0;
      while (busy && w < 100) begin
         ats_stat = 2'($urandom);
         ats_data = 24'($urandom);
         step();
         w++;
      end
      chk(nm, 32'(w < 100), 32'd1);
   endtask

   task automatic wait_drained(input string nm, input int lim);
      int w;
      w = 0;
      while ((busy || qa.size() > 0 || qb.size() > 0) && w < lim) begin
         step();
         w++;
      end
      chk(nm, 32'(w < lim), 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      #2 reset = 1'b1;
      #1 chk("rel_a_ready", 32'(a_ready), 32'd1);
      step(); step();

      // Paired A/B transaction with fastest response
      a_valid = 1; a_instr = 32'h2000_0000; b_valid = 1; b_instr = 32'h2240_0000;
      step(); a_valid = 0; b_valid = 0;
      chk("t1_req_early", 32'(req), 32'd0);
      step(); chk("t1_req", 32'(req), 32'd1);
      step(); chk("t1_hiA", 32'(ctrlA), 32'h2000); chk("t1_hiB", 32'(ctrlB), 32'h2240);
      chk("t1_req_off", 32'(req), 32'd0);
      step(); chk("t1_loA", 32'(ctrlA), 32'h0); chk("t1_loB", 32'(ctrlB), 32'h0);
      step();
      ats_ready = 1; ats_stat = 2'b01; ats_data = 24'h00ABCD;
      step(); ats_ready = 0;
      chk("t1_rv", 32'(rsp_valid), 32'd1); chk("t1_stat", 32'(rsp_stat), 32'h1);
      chk("t1_data", 32'(rsp_data), 32'h00ABCD); chk("t1_tmo", 32'(rsp_timeout), 32'd0);
      step(); chk("t1_rv_pulse", 32'(rsp_valid), 32'd0);

      // A only, with an early ats_ready that must be ignored
      a_valid = 1; a_instr = 32'hA382_1234;
      step(); a_valid = 0;
      step(); chk("t2_req", 32'(req), 32'd1);
      step(); chk("t2_hiA", 32'(ctrlA), 32'hA382); chk("t2_hiB", 32'(ctrlB), 32'h0);
      ats_ready = 1; ats_stat = 2'b10; ats_data = 24'h111111;
      step(); ats_ready = 0;
      chk("t2_loA", 32'(ctrlA), 32'h1234); chk("t2_loB", 32'(ctrlB), 32'h0);
      chk("t2_ignored", 32'(rsp_valid), 32'd0);
      step(); step(); step();
      ats_ready = 1; ats_stat = 2'b10; ats_data = 24'h00BEEF;
      step(); ats_ready = 0;
      chk("t2_rv", 32'(rsp_valid), 32'd1); chk("t2_data", 32'(rsp_data), 32'h00BEEF);
      step();

      // DEPTH+1 pushes on A with no responses: fill, timeouts, ordered drain
      for (int k = 0; k < 5; k++) begin
         int w; logic r;
         w = 0;
         a_valid = 1; a_instr = 32'hC000_0000 + 32'(k) * 32'h0001_0001;
         do begin r = a_ready; step(); w++; end while (!r && w < 100);
         chk("t3_accept", 32'(r), 32'd1);
      end
      a_valid = 0;
      chk("t3_full", 32'(a_ready), 32'd0);
      begin
         int w, lat;
         w = 0;
         while (!req && w < 100) begin step(); w++; end
         chk("t3_req_seen", 32'(w < 100), 32'd1);
         lat = 0;
         while (!rsp_valid && lat < 100) begin step(); lat++; end
         chk("t3_tmo_latency", 32'(lat), 32'd19);
         chk("t3_tmo_flag", 32'(rsp_timeout), 32'd1);
         chk("t3_tmo_stat", 32'(rsp_stat), 32'h3);
         chk("t3_tmo_data", 32'(rsp_data), 32'h0);
      end
      wait_drained("t3_drain", 400);
      chk("t3_txn_count", 32'(n_txn), 32'd7);

      // Reset during WORD_LO with two entries still queued
      a_valid = 1; a_instr = 32'h5111_5222; step();
      a_instr = 32'h5333_5444; step();
      a_instr = 32'h5555_5666; step();
      a_valid = 0; step();
      chk("t4_lo", 32'(ctrlA), 32'h5222);
      #2 reset = 1'b0;
      #1;
      chk("t4_ctrl0", 32'(ctrlA), 32'h0); chk("t4_busy0", 32'(busy), 32'd0);
      chk("t4_ready0", 32'(a_ready), 32'd0);
      step(); step();
      #2 reset = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 30; i++) begin
            step();
            seen = seen | req | busy | rsp_valid;
         end
         chk("t4_quiet", 32'(seen), 32'd0);
      end

      // Steady push/pop at count 2 over 10 transactions (pointer wrap)
      ats_ready = 1;
      a_valid = 1; a_instr = 32'h1000_0001; step();
      a_instr = 32'h1000_0002; step();
      a_instr = 32'h1000_0003; step();
      a_valid = 0;
      for (int k = 0; k < 10; k++) begin
         wait_not_busy("t5_idle");
         a_valid = 1; a_instr = 32'h1100_0000 + 32'(k);
         step(); a_valid = 0;
         chk("t5_count", 32'(dut.u_fifo_a.count), 32'd2);
      end
      wait_drained("t5_drain", 200);
      ats_ready = 0;

      // Randomized traffic on both clients
      for (int i = 0; i < 800; i++) begin
         a_valid   = ($urandom_range(0, 3) == 0);
         b_valid   = ($urandom_range(0, 3) == 0);
         a_instr   = $urandom;
         b_instr   = $urandom;
         ats_ready = ($urandom_range(0, 9) == 0);
         ats_stat  = 2'($urandom);
         ats_data  = 24'($urandom);
         step();
      end
      a_valid = 0; b_valid = 0; ats_ready = 0;
      wait_drained("rand_drain", 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
